// File: rtl/kernel_kxk_stride_sxs_pkg.sv
// Shared defaults and small helpers for the sliding-window generator and its
// downstream stages (MAC, pooling): image geometry defaults, counter widths, bus slicing.
package kernel_kxk_stride_sxs_pkg;

   localparam int DEF_DATA_WIDHT = 8;
   localparam int DEF_IMG_WIDHT  = 299;
   localparam int DEF_IMG_HEIGHT = 299;

   // Counter width for a range 0..n-1, never narrower than one bit.
   function automatic int ctrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Base bit index of window element (r,c) in a flattened KxK bus.
   function automatic int winBase(input int r, input int c, input int k, input int w);
      return (r * k + c) * w;
   endfunction

endpackage

// File: rtl/kernel_kxk_stride_sxs_line_buffer.sv
// One-row delay line: a circular buffer of DEPTH pixels that advances only when
// shift_en_i is high, so data_o is the pixel accepted exactly DEPTH accepts earlier.
module kernel_kxk_stride_sxs_line_buffer
   import kernel_kxk_stride_sxs_pkg::*;
#(
   parameter int DATA_WIDHT = DEF_DATA_WIDHT,
   parameter int DEPTH      = DEF_IMG_WIDHT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  shift_en_i,
   input  logic [DATA_WIDHT-1:0] data_i,
   output logic [DATA_WIDHT-1:0] data_o
);

   localparam int AW = ctrWidth(DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [DATA_WIDHT-1:0] mem_q [DEPTH];
   logic [AW-1:0]         ptr_q;
   logic [AW-1:0]         ptr_d;

   // Read-before-write at the same slot gives the DEPTH-accept delay.
   assign data_o = mem_q[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (shift_en_i) begin
         ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en_i) begin
         mem_q[ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/kernel_kxk_stride_sxs.sv
// Streaming KxK sliding-window generator with stride S over a raster pixel stream;
// emits one registered window per stride point and pulses Frame_Done at frame end.
module kernel_kxk_stride_sxs
   import kernel_kxk_stride_sxs_pkg::*;
#(
   parameter int DATA_WIDHT = DEF_DATA_WIDHT,
   parameter int IMG_WIDHT  = DEF_IMG_WIDHT,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int KERNEL     = 3,
   parameter int STRIDE     = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [DATA_WIDHT-1:0]                 Data_In,
   input  logic                                  Valid_in,
   output logic [KERNEL*KERNEL*DATA_WIDHT-1:0]   Data_Out,
   output logic                                  Valid_Out,
   output logic                                  Frame_Done
);

   localparam int CW = ctrWidth(IMG_WIDHT);
   localparam int RW = ctrWidth(IMG_HEIGHT);
   localparam int PW = ctrWidth(STRIDE);
   localparam int BW = KERNEL * KERNEL * DATA_WIDHT;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDHT - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
   localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] colPh_q, colPh_d;
   logic [PW-1:0] rowPh_q, rowPh_d;
   logic          colEnd, rowEnd, emit;

   logic [DATA_WIDHT-1:0] lbOut  [KERNEL-1];
   logic [DATA_WIDHT-1:0] newCol [KERNEL];
   logic [DATA_WIDHT-1:0] win_q  [KERNEL][KERNEL];
   logic [DATA_WIDHT-1:0] win_d  [KERNEL][KERNEL];
   logic [BW-1:0]         winFlat;

   logic [BW-1:0] dataOut_q, dataOut_d;
   logic          validOut_q, validOut_d;
   logic          frameDone_q, frameDone_d;

   // Cascaded line buffers: buffer j delivers the pixel j+1 rows above the current one.
   for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
      if (j == 0) begin : g_first
         kernel_kxk_stride_sxs_line_buffer #(
            .DATA_WIDHT(DATA_WIDHT),
            .DEPTH     (IMG_WIDHT)
         ) u_lb (
            .clk       (clk),
            .rst       (rst),
            .shift_en_i(Valid_in),
            .data_i    (Data_In),
            .data_o    (lbOut[j])
         );
      end else begin : g_next
         kernel_kxk_stride_sxs_line_buffer #(
            .DATA_WIDHT(DATA_WIDHT),
            .DEPTH     (IMG_WIDHT)
         ) u_lb (
            .clk       (clk),
            .rst       (rst),
            .shift_en_i(Valid_in),
            .data_i    (lbOut[j-1]),
            .data_o    (lbOut[j])
         );
      end
   end

   // Incoming right column (oldest row on top), then the window after this accept's shift.
   always_comb begin
      for (int r = 0; r < KERNEL - 1; r++) begin
         newCol[r] = lbOut[KERNEL - 2 - r];
      end
      newCol[KERNEL-1] = Data_In;
      for (int r = 0; r < KERNEL; r++) begin
         for (int c = 0; c < KERNEL - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
         end
         win_d[r][KERNEL-1] = newCol[r];
      end
      winFlat = '0;
      for (int r = 0; r < KERNEL; r++) begin
         for (int c = 0; c < KERNEL; c++) begin
            winFlat[winBase(r, c, KERNEL, DATA_WIDHT) +: DATA_WIDHT] = win_d[r][c];
         end
      end
   end

   // Phase counters replace (pos-(K-1)) mod S: they stay at zero until the first
   // full-window position, then cycle 0..S-1; zero in both means a stride point.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      colPh_d     = colPh_q;
      rowPh_d     = rowPh_q;
      colEnd      = (col_q == COL_LAST);
      rowEnd      = (row_q == ROW_LAST);
      emit        = Valid_in && (col_q >= COL_K) && (row_q >= ROW_K) &&
                    (colPh_q == '0) && (rowPh_q == '0);
      frameDone_d = Valid_in && colEnd && rowEnd;
      validOut_d  = emit;
      dataOut_d   = emit ? winFlat : dataOut_q;
      if (Valid_in) begin
         if (colEnd) begin
            col_d   = '0;
            colPh_d = '0;
            if (rowEnd) begin
               row_d   = '0;
               rowPh_d = '0;
            end else begin
               row_d = row_q + RW'(1);
               if (row_q >= ROW_K) begin
                  rowPh_d = (rowPh_q == PH_LAST) ? '0 : rowPh_q + PW'(1);
               end
            end
         end else begin
            col_d = col_q + CW'(1);
            if (col_q >= COL_K) begin
               colPh_d = (colPh_q == PH_LAST) ? '0 : colPh_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q       <= '0;
         row_q       <= '0;
         colPh_q     <= '0;
         rowPh_q     <= '0;
         dataOut_q   <= '0;
         validOut_q  <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         colPh_q     <= colPh_d;
         rowPh_q     <= rowPh_d;
         dataOut_q   <= dataOut_d;
         validOut_q  <= validOut_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Window contents are only exposed at full-window positions, so no reset is needed.
   always_ff @(posedge clk) begin
      if (Valid_in) begin
         win_q <= win_d;
      end
   end

   assign Data_Out   = dataOut_q;
   assign Valid_Out  = validOut_q;
   assign Frame_Done = frameDone_q;

endmodule

// File: tb/tb_kernel_kxk_stride_sxs.sv
// Self-checking bench: five differently parameterised instances share one stimulus port
// selected by 'sel'; a coordinate-based window model predicts every output cycle.
module tb_kernel_kxk_stride_sxs;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] dIn;
   logic       vIn;
   int         sel;

   always #5 clk = ~clk;

   logic vA, vB, vC, vD, vE;
   assign vA = vIn && (sel == 0);
   assign vB = vIn && (sel == 1);
   assign vC = vIn && (sel == 2);
   assign vD = vIn && (sel == 3);
   assign vE = vIn && (sel == 4);

   logic [31:0]  dA, dD;
   logic [71:0]  dB, dC;
   logic [127:0] dE;
   logic valA, valB, valC, valD, valE;
   logic donA, donB, donC, donD, donE;

   kernel_kxk_stride_sxs #(.DATA_WIDHT(8), .IMG_WIDHT(4), .IMG_HEIGHT(4), .KERNEL(2), .STRIDE(2)) uA (
      .clk(clk), .rst(rst), .Data_In(dIn), .Valid_in(vA), .Data_Out(dA), .Valid_Out(valA), .Frame_Done(donA));
   kernel_kxk_stride_sxs #(.DATA_WIDHT(8), .IMG_WIDHT(5), .IMG_HEIGHT(5), .KERNEL(3), .STRIDE(1)) uB (
      .clk(clk), .rst(rst), .Data_In(dIn), .Valid_in(vB), .Data_Out(dB), .Valid_Out(valB), .Frame_Done(donB));
   kernel_kxk_stride_sxs #(.DATA_WIDHT(8), .IMG_WIDHT(7), .IMG_HEIGHT(7), .KERNEL(3), .STRIDE(2)) uC (
      .clk(clk), .rst(rst), .Data_In(dIn), .Valid_in(vC), .Data_Out(dC), .Valid_Out(valC), .Frame_Done(donC));
   kernel_kxk_stride_sxs #(.DATA_WIDHT(8), .IMG_WIDHT(299), .IMG_HEIGHT(20), .KERNEL(2), .STRIDE(2)) uD (
      .clk(clk), .rst(rst), .Data_In(dIn), .Valid_in(vD), .Data_Out(dD), .Valid_Out(valD), .Frame_Done(donD));
   kernel_kxk_stride_sxs #(.DATA_WIDHT(8), .IMG_WIDHT(13), .IMG_HEIGHT(11), .KERNEL(4), .STRIDE(3)) uE (
      .clk(clk), .rst(rst), .Data_In(dIn), .Valid_in(vE), .Data_Out(dE), .Valid_Out(valE), .Frame_Done(donE));

   logic [127:0] outData;
   logic         outValid, outDone;

   always_comb begin
      outData  = '0;
      outValid = 1'b0;
      outDone  = 1'b0;
      case (sel)
         0: begin outData = 128'(dA); outValid = valA; outDone = donA; end
         1: begin outData = 128'(dB); outValid = valB; outDone = donB; end
         2: begin outData = 128'(dC); outValid = valC; outDone = donC; end
         3: begin outData = 128'(dD); outValid = valD; outDone = donD; end
         default: begin outData = dE; outValid = valE; outDone = donE; end
      endcase
   end

   int dimW [5] = '{4, 5, 7, 299, 13};
   int dimH [5] = '{4, 5, 7, 20, 11};
   int dimK [5] = '{2, 3, 3, 2, 4};
   int dimS [5] = '{2, 1, 2, 2, 3};

   int           vectors = 0;
   int           miscompares = 0;
   int           idxArr [5];
   logic [127:0] lastData [5];
   logic [7:0]   mem [8192];
   int           winCnt, doneCnt;
   logic [127:0] firstWin, lastWinSeen;
   logic [7:0]   tlq [$];

   typedef struct {
      logic [7:0]  pix;
      logic        expValid;
      logic [31:0] expData;
      logic        expDone;
   } vec_t;
   vec_t tbl [16];

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int expectedWindows(input int s);
      return ((dimW[s] - dimK[s]) / dimS[s] + 1) * ((dimH[s] - dimK[s]) / dimS[s] + 1);
   endfunction

   // Model: window at raster position (r,c) is emitted when it is complete and on the stride grid.
   task automatic applyStimulus(input logic [7:0] p, input bit v);
      logic         expValid, expDone;
      logic [127:0] win;
      int           r, c, W, K, S, idx;
      W = dimW[sel]; K = dimK[sel]; S = dimS[sel]; idx = idxArr[sel];
      expValid = 1'b0;
      expDone  = 1'b0;
      dIn = p;
      vIn = v;
      if (v) begin
         mem[idx] = p;
         r = idx / W;
         c = idx % W;
         if (r >= K - 1 && c >= K - 1 && (r - K + 1) % S == 0 && (c - K + 1) % S == 0) begin
            win = '0;
            for (int rr = 0; rr < K; rr++)
               for (int cc = 0; cc < K; cc++)
                  win[(rr * K + cc) * 8 +: 8] = mem[(r - K + 1 + rr) * W + (c - K + 1 + cc)];
            expValid = 1'b1;
            lastData[sel] = win;
         end
         expDone = (idx == W * dimH[sel] - 1);
         idxArr[sel] = expDone ? 0 : idx + 1;
      end
      @(posedge clk);
      #1;
      checkOutput("valid_out", 128'(outValid), 128'(expValid));
      checkOutput("data_out", outData, lastData[sel]);
      checkOutput("frame_done", 128'(outDone), 128'(expDone));
      if (outValid) begin
         if (winCnt == 0) firstWin = outData;
         lastWinSeen = outData;
         tlq.push_back(outData[7:0]);
         winCnt++;
      end
      if (outDone) doneCnt++;
      vIn = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      vIn = 1'b0;
      dIn = '0;
      sel = 0;
      for (int s = 0; s < 5; s++) begin
         idxArr[s]   = 0;
         lastData[s] = '0;
      end

      // 2x2 stride-2 reference table on a 4x4 ramp.
      for (int i = 0; i < 16; i++) begin
         tbl[i].pix      = 8'(i);
         tbl[i].expValid = 1'b0;
         tbl[i].expData  = 32'h0;
         tbl[i].expDone  = 1'b0;
      end
      tbl[5].expValid  = 1'b1; tbl[5].expData  = 32'h05040100;
      tbl[7].expValid  = 1'b1; tbl[7].expData  = 32'h07060302;
      tbl[13].expValid = 1'b1; tbl[13].expData = 32'h0d0c0908;
      tbl[15].expValid = 1'b1; tbl[15].expData = 32'h0f0e0b0a;
      tbl[15].expDone  = 1'b1;
      for (int i = 1; i < 16; i++)
         if (!tbl[i].expValid) tbl[i].expData = tbl[i-1].expData;

      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 5; s++) begin
         sel = s;
         #1;
         checkOutput("reset_data", outData, 128'h0);
         checkOutput("reset_valid", 128'(outValid), 128'h0);
         checkOutput("reset_done", 128'(outDone), 128'h0);
      end
      rst = 1'b1;

      $display("[TB] case 1: K=2 S=2 4x4 table");
      sel = 0;
      for (int i = 0; i < 16; i++) begin
         dIn = tbl[i].pix;
         vIn = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("tbl_valid", 128'(outValid), 128'(tbl[i].expValid));
         checkOutput("tbl_data", outData, 128'(tbl[i].expData));
         checkOutput("tbl_done", 128'(outDone), 128'(tbl[i].expDone));
      end
      vIn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idle_valid", 128'(outValid), 128'h0);
      checkOutput("idle_hold", outData, 128'(32'h0f0e0b0a));

      $display("[TB] case 2: K=3 S=1 5x5 ramp");
      sel = 1; winCnt = 0; doneCnt = 0;
      for (int i = 0; i < 25; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("c2_count", 128'(winCnt), 128'(9));
      checkOutput("c2_first", firstWin, 128'(72'h0c0b0a070605020100));
      checkOutput("c2_last", lastWinSeen, 128'(72'h1817161312110e0d0c));
      checkOutput("c2_done", 128'(doneCnt), 128'(1));

      $display("[TB] case 3: K=3 S=1 5x5 ramp with gaps");
      winCnt = 0; doneCnt = 0;
      for (int i = 0; i < 25; i++) begin
         while ($urandom_range(99) < 40) applyStimulus(8'($urandom), 1'b0);
         applyStimulus(8'(i), 1'b1);
      end
      repeat (3) applyStimulus(8'h5a, 1'b0);
      checkOutput("c3_count", 128'(winCnt), 128'(9));
      checkOutput("c3_first", firstWin, 128'(72'h0c0b0a070605020100));
      checkOutput("c3_last", lastWinSeen, 128'(72'h1817161312110e0d0c));

      $display("[TB] case 4: K=3 S=2 7x7 ramp");
      sel = 2; winCnt = 0; doneCnt = 0;
      tlq.delete();
      for (int i = 0; i < 49; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("c4_count", 128'(winCnt), 128'(expectedWindows(2)));
      if (tlq.size() > 3) begin
         checkOutput("c4_tl0", 128'(tlq[0]), 128'(0));
         checkOutput("c4_tl1", 128'(tlq[1]), 128'(2));
         checkOutput("c4_tl3", 128'(tlq[3]), 128'(14));
      end

      $display("[TB] case 5: reset mid-row 3, then fresh frame");
      sel = 1; winCnt = 0; doneCnt = 0;
      for (int i = 0; i < 18; i++) applyStimulus(8'($urandom), 1'b1);
      rst = 1'b0;
      #1;
      checkOutput("c5_rst_data", outData, 128'h0);
      checkOutput("c5_rst_valid", 128'(outValid), 128'h0);
      checkOutput("c5_rst_done", 128'(outDone), 128'h0);
      for (int s = 0; s < 5; s++) begin
         idxArr[s]   = 0;
         lastData[s] = '0;
      end
      dIn = 8'haa;
      vIn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("c5_rst_data2", outData, 128'h0);
      checkOutput("c5_rst_valid2", 128'(outValid), 128'h0);
      vIn = 1'b0;
      #2 rst = 1'b1;
      winCnt = 0;
      for (int i = 0; i < 25; i++) applyStimulus(8'(100 + i), 1'b1);
      checkOutput("c5_count", 128'(winCnt), 128'(9));
      checkOutput("c5_done", 128'(doneCnt), 128'(1));

      $display("[TB] case 6: K=2 S=2 299-wide, two back-to-back frames");
      sel = 3; doneCnt = 0;
      for (int f = 0; f < 2; f++) begin
         winCnt = 0;
         for (int i = 0; i < 299 * 20; i++) applyStimulus(8'(i % 256), 1'b1);
         checkOutput("c6_count", 128'(winCnt), 128'(expectedWindows(3)));
      end
      checkOutput("c6_done", 128'(doneCnt), 128'(2));

      $display("[TB] case 7: K=4 S=3 13x11 random pixels with gaps");
      sel = 4; doneCnt = 0;
      for (int f = 0; f < 2; f++) begin
         winCnt = 0;
         for (int i = 0; i < 13 * 11; i++) begin
            if ($urandom_range(99) < 30) applyStimulus(8'($urandom), 1'b0);
            applyStimulus(8'($urandom), 1'b1);
         end
         checkOutput("c7_count", 128'(winCnt), 128'(expectedWindows(4)));
      end
      checkOutput("c7_done", 128'(doneCnt), 128'(2));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
